pwm_ramp_sequencer: RTL and testbench
=====================================

Name: pwm_ramp_sequencer

Overview:
- Controller that configures and sequences a bank of PWM driver instances sharing one period.
- Owns a free-running period counter and accepts per-channel target duties over a valid/ready command port.
- Once per PWM period, walks the channels and slews each registered duty output toward its target by a bounded step.
- Sits between the register/command interface and the PWM drivers; its cycle and duty outputs feed the drivers directly.

Parameters:
- COUNTER_BITS, 32, width of cycle, duty, step and the period counter.
- CHANNELS, 4, number of PWM channels driven (min 1).
- CH_BITS, 2, width of cmd_channel; must be at least $clog2(CHANNELS), and 1 when CHANNELS = 1.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- cycle  in  COUNTER_BITS  requested PWM period in clk ticks; sampled only at a period boundary.
- step  in  COUNTER_BITS  max duty change per channel per period; 0 means jump directly to target.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted this cycle when cmd_valid && cmd_ready.
- cmd_channel  in  CH_BITS  target channel index.
- cmd_duty  in  COUNTER_BITS  new target duty.
- cycle_out  out  COUNTER_BITS  latched period to all drivers.
- duty_flat  out  CHANNELS*COUNTER_BITS  current duties; channel i at bits [i*COUNTER_BITS +: COUNTER_BITS].
- period_tick  out  1  one-cycle pulse on the last clk of each period.
- update_done  out  1  one-cycle pulse when a channel walk completes.
- cmd_err  out  1  one-cycle pulse when an accepted command has an out-of-range channel.
- overrun  out  1  sticky flag: a period_tick arrived while a walk was still in progress.

Behaviour:
- Reset (async): cycle_q = 0, pcnt = 0, all duties = 0, all targets = 0, FSM = IDLE. All pulse outputs = 0, overrun = 0, cmd_ready = 0 while reset is asserted.
- Period counter:
  - If cycle_q == 0, pcnt holds 0, no tick is generated, and cycle_q loads cycle on the next clk.
  - Otherwise pcnt counts 0..cycle_q-1. period_tick = 1 when pcnt == cycle_q-1.
  - On that clk, pcnt wraps to 0 and cycle_q loads cycle. A cycle change never truncates a running period.
  - If cycle is 0 at the wrap, the counter halts per the rule above.
- cycle_out = cycle_q (registered).
- Commands:
  - cmd_ready = 1 only in IDLE and when period_tick is 0 that cycle.
  - On accept with cmd_channel < CHANNELS: target[cmd_channel] <= cmd_duty.
  - On accept with cmd_channel >= CHANNELS: no state change; cmd_err pulses on the next cycle.
  - Repeated commands to the same channel are last-write-wins.
- FSM states: IDLE, WALK, DONE.
  - IDLE -> WALK on period_tick, with idx = 0.
  - WALK: updates channel idx once per clk; idx increments; after idx == CHANNELS-1, go to DONE.
  - DONE: update_done = 1 for one clk, then return to IDLE.
  - Walk length is CHANNELS+1 clks. A tick at clk t updates channel i at edge t+1+i; update_done is high in clk t+CHANNELS+1.
- Slew rule per channel, with eff = min(target, cycle_q) clamped in COUNTER_BITS unsigned:
  - If duty < eff: duty += (step == 0 || eff-duty <= step) ? eff-duty : step.
  - If duty > eff: symmetric decrement.
  - Equal: hold.
  - Never overshoots; no arithmetic wrap. Differences are computed unsigned after the compare.
- Duty outputs change only during WALK. A cycle shrink below the current duty pulls duty down at the normal slew on later periods.
- period_tick during WALK or DONE: overrun <= 1 (sticky until reset); that tick is ignored, and the walk finishes normally.
- Reset mid-walk: immediate return to reset values; the partial walk is discarded.

Optional Feature:
- Macro PWM_RAMP_SEQUENCER_BUSY_EN.
- When defined:
  - Adds output busy_mask [CHANNELS-1:0].
  - Bit i = 1 while duty[i] != min(target[i], cycle_q).
  - Combinational from registered state; 0 after reset.
  - Also adds output all_settled = (busy_mask == 0) && FSM == IDLE.
- When undefined: neither port exists, and no comparison logic is generated.

Test Plan:
- Reset/halt:
  - Hold reset=0, then release with cycle=0 -> no period_tick, cmd_ready=1, all outputs 0.
  - Set cycle=10 -> cycle_out=10, and period_tick every 10 clks.
- Ramp up:
  - CHANNELS=4, cycle=100, step=8; command ch1 duty=30 -> ch1 duty goes 8, 16, 24, 30 on four successive periods. Other channels stay 0.
  - update_done pulses each period, 5 clks after the tick.
- Jump and clamp:
  - step=0, ch0 duty=250 with cycle=100 -> ch0 duty=100 after the first walk.
  - Then cycle=50 -> cycle_out=50 at the next wrap; ch0 = 50 after the following walk.
- Handshake/error:
  - cmd_valid held with cmd_channel=5 (CH_BITS=3, CHANNELS=4) -> accepted, cmd_err pulse, no duty change.
  - cmd_ready=0 on the tick clk and throughout WALK/DONE.
- Overrun:
  - cycle=3, CHANNELS=4 -> a second tick lands during WALK, and overrun latches to 1.
  - Duties still advance one step per completed walk.
- Reset mid-walk:
  - Assert reset during WALK at idx=2 -> all duties and targets 0 asynchronously; overrun = 0.
  - FSM returns to IDLE.

Source files
------------

// File: rtl/pwm_ramp_sequencer.sv
// pwm_ramp_sequencer: shared-period PWM controller. It accepts per-channel target duties and slews the registered duty outputs toward them once per period.
// Latency: a tick in clk t updates channel i at the end of clk t+1+i, and update_done is high in clk t+CHANNELS+1.
// Backpressure: cmd_ready is low on the tick clk and throughout WALK/DONE. Optional busy_mask/all_settled ports exist under `PWM_RAMP_SEQUENCER_BUSY_EN.
module pwm_ramp_sequencer #(
    parameter int COUNTER_BITS = 32,
    parameter int CHANNELS     = 4,
    parameter int CH_BITS      = 2
) (
    input  logic                             i_clk,
    input  logic                             i_reset,        // active-low, asynchronous
    input  logic [COUNTER_BITS-1:0]          i_cycle,
    input  logic [COUNTER_BITS-1:0]          i_step,
    input  logic                             i_cmd_valid,
    output logic                             o_cmd_ready,
    input  logic [CH_BITS-1:0]               i_cmd_channel,
    input  logic [COUNTER_BITS-1:0]          i_cmd_duty,
    output logic [COUNTER_BITS-1:0]          o_cycle_out,
    output logic [CHANNELS*COUNTER_BITS-1:0] o_duty_flat,
    output logic                             o_period_tick,
    output logic                             o_update_done,
    output logic                             o_cmd_err,
`ifdef PWM_RAMP_SEQUENCER_BUSY_EN
    output logic [CHANNELS-1:0]              o_busy_mask,
    output logic                             o_all_settled,
`endif
    output logic                             o_overrun
);

    localparam int IDX_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WALK, S_DONE} state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [COUNTER_BITS-1:0]   r_cycle_q;
    logic [COUNTER_BITS-1:0]   r_pcnt;
    logic [COUNTER_BITS-1:0]   r_duty   [CHANNELS];
    logic [COUNTER_BITS-1:0]   r_target [CHANNELS];
    logic [IDX_BITS-1:0]       r_idx;
    logic                      r_cmd_err;
    logic                      r_overrun;

    logic                      w_tick;
    logic                      w_accept;
    logic                      w_ch_ok;
    logic                      w_last_idx;
    logic [COUNTER_BITS-1:0]   w_cur;
    logic [COUNTER_BITS-1:0]   w_tgt;
    logic [COUNTER_BITS-1:0]   w_eff;
    logic [COUNTER_BITS-1:0]   w_diff;
    logic [COUNTER_BITS-1:0]   w_slew;

    // A zero period halts the counter, so the tick is qualified by a non-zero cycle_q.
    assign w_tick     = (r_cycle_q != '0) && (r_pcnt == r_cycle_q - COUNTER_BITS'(1));
    assign w_accept   = i_cmd_valid && o_cmd_ready;
    // Compare at 32 bits so that CH_BITS narrower or wider than the channel count never truncates.
    assign w_ch_ok    = 32'(i_cmd_channel) < $unsigned(CHANNELS);
    assign w_last_idx = (r_idx == IDX_BITS'(CHANNELS - 1));

    // Period counter. cycle_q reloads only at a wrap or while halted, so a running period is never cut short.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cycle_q <= '0;
            r_pcnt    <= '0;
        end else if (r_cycle_q == '0) begin
            r_pcnt    <= '0;
            r_cycle_q <= i_cycle;
        end else if (w_tick) begin
            r_pcnt    <= '0;
            r_cycle_q <= i_cycle;
        end else begin
            r_pcnt    <= r_pcnt + COUNTER_BITS'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state. Ticks that arrive in WALK or DONE are ignored here and only flagged as overrun.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_tick) w_state_nxt = S_WALK;
            S_WALK:  if (w_last_idx) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs. Gating with reset keeps cmd_ready low for as long as reset is held.
    always_comb begin
        o_update_done = (r_state == S_DONE);
        o_cmd_ready   = i_reset && (r_state == S_IDLE) && !w_tick;
    end

    // Walk index. It restarts at 0 on each accepted tick and advances once per WALK clk.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_idx <= '0;
        end else if (r_state == S_IDLE) begin
            r_idx <= '0;
        end else if (r_state == S_WALK && !w_last_idx) begin
            r_idx <= r_idx + IDX_BITS'(1);
        end
    end

    // Slew for the channel being walked: move toward min(target, cycle_q) without overshoot.
    always_comb begin
        w_cur  = '0;
        w_tgt  = '0;
        w_diff = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if ($unsigned(i) == 32'(r_idx)) begin
                w_cur = r_duty[i];
                w_tgt = r_target[i];
            end
        end
        w_eff  = (w_tgt < r_cycle_q) ? w_tgt : r_cycle_q;
        w_slew = w_cur;
        if (w_cur < w_eff) begin
            w_diff = w_eff - w_cur;
            w_slew = (i_step == '0 || w_diff <= i_step) ? w_eff : w_cur + i_step;
        end else if (w_cur > w_eff) begin
            w_diff = w_cur - w_eff;
            w_slew = (i_step == '0 || w_diff <= i_step) ? w_eff : w_cur - i_step;
        end
    end

    // Target capture (last write wins) and duty update for the walked channel.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_duty[i]   <= '0;
                r_target[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_accept && w_ch_ok && 32'(i_cmd_channel) == $unsigned(i)) begin
                    r_target[i] <= i_cmd_duty;
                end
                if (r_state == S_WALK && 32'(r_idx) == $unsigned(i)) begin
                    r_duty[i] <= w_slew;
                end
            end
        end
    end

    // Error pulse for accepted bad channels, plus the sticky overrun flag.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cmd_err <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_cmd_err <= w_accept && !w_ch_ok;
            if (w_tick && r_state != S_IDLE) begin
                r_overrun <= 1'b1;
            end
        end
    end

    // Flatten the duty registers onto the driver bus.
    always_comb begin
        o_duty_flat = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            o_duty_flat[i*COUNTER_BITS +: COUNTER_BITS] = r_duty[i];
        end
    end

    assign o_cycle_out   = r_cycle_q;
    assign o_period_tick = w_tick;
    assign o_cmd_err     = r_cmd_err;
    assign o_overrun     = r_overrun;

`ifdef PWM_RAMP_SEQUENCER_BUSY_EN
    // A channel is busy while its duty differs from its effective (clamped) target.
    always_comb begin
        o_busy_mask = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            o_busy_mask[i] = r_duty[i] != ((r_target[i] < r_cycle_q) ? r_target[i] : r_cycle_q);
        end
        o_all_settled = (o_busy_mask == '0) && (r_state == S_IDLE);
    end
`endif

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Directed bench for pwm_ramp_sequencer (CHANNELS=4, CH_BITS=3).
// Table vectors cover ramp, jump, clamp and cycle shrink. Hand sequences cover reset, latency, errors, overrun and reset mid-walk.
// Outputs are sampled on the falling edge, and inputs are driven on the falling edge.
module tb_pwm_ramp_sequencer;

    localparam int CB  = 32;
    localparam int NCH = 4;
    localparam int CHB = 3;

    logic              i_clk;
    logic              i_reset;
    logic [CB-1:0]     i_cycle;
    logic [CB-1:0]     i_step;
    logic              i_cmd_valid;
    logic              o_cmd_ready;
    logic [CHB-1:0]    i_cmd_channel;
    logic [CB-1:0]     i_cmd_duty;
    logic [CB-1:0]     o_cycle_out;
    logic [NCH*CB-1:0] o_duty_flat;
    logic              o_period_tick;
    logic              o_update_done;
    logic              o_cmd_err;
    logic              o_overrun;
`ifdef PWM_RAMP_SEQUENCER_BUSY_EN
    logic [NCH-1:0]    o_busy_mask;
    logic              o_all_settled;
`endif

    pwm_ramp_sequencer #(.COUNTER_BITS(CB), .CHANNELS(NCH), .CH_BITS(CHB)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_cycle       (i_cycle),
        .i_step        (i_step),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_channel (i_cmd_channel),
        .i_cmd_duty    (i_cmd_duty),
        .o_cycle_out   (o_cycle_out),
        .o_duty_flat   (o_duty_flat),
        .o_period_tick (o_period_tick),
        .o_update_done (o_update_done),
        .o_cmd_err     (o_cmd_err),
`ifdef PWM_RAMP_SEQUENCER_BUSY_EN
        .o_busy_mask   (o_busy_mask),
        .o_all_settled (o_all_settled),
`endif
        .o_overrun     (o_overrun)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] cyc;
        logic [31:0] stp;
        bit          do_cmd;
        logic [2:0]  ch;
        logic [31:0] duty;
        logic [31:0] exp_cyc;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] d3;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] duty_of(input int i);
        return o_duty_flat[i*CB +: CB];
    endfunction

    task automatic wait_done();
        bit ok;
        int n;
        ok = 0;
        n  = 0;
        while (!ok && n < 2000) begin
            @(negedge i_clk);
            ok = o_update_done;
            n++;
        end
        if (!ok) check("timeout_update_done", 32'd0, 32'd1);
    endtask

    task automatic wait_tick();
        bit ok;
        int n;
        ok = 0;
        n  = 0;
        while (!ok && n < 2000) begin
            @(negedge i_clk);
            ok = o_period_tick;
            n++;
        end
        if (!ok) check("timeout_period_tick", 32'd0, 32'd1);
    endtask

    // Called at a falling edge. Returns at the falling edge after the accepting rising edge.
    task automatic send_cmd(input logic [2:0] ch, input logic [31:0] duty);
        bit ok;
        int n;
        i_cmd_valid   = 1'b1;
        i_cmd_channel = ch;
        i_cmd_duty    = duty;
        ok = 0;
        n  = 0;
        while (!ok && n < 500) begin
            if (o_cmd_ready) ok = 1;
            else begin
                @(negedge i_clk);
                n++;
            end
        end
        if (!ok) check("timeout_cmd_ready", 32'd0, 32'd1);
        @(posedge i_clk);
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic check_duties(input string nm, input logic [31:0] e0, input logic [31:0] e1,
                                input logic [31:0] e2, input logic [31:0] e3);
        check({nm, "_ch0"}, duty_of(0), e0);
        check({nm, "_ch1"}, duty_of(1), e1);
        check({nm, "_ch2"}, duty_of(2), e2);
        check({nm, "_ch3"}, duty_of(3), e3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks;
        int dones;

        //             cyc  stp cmd ch duty  exp_cyc d0   d1  d2  d3
        tbl[0]  = '{100, 8, 1, 1, 30,   100,  0,  8,  0,  0};
        tbl[1]  = '{100, 8, 0, 0, 0,    100,  0, 16,  0,  0};
        tbl[2]  = '{100, 8, 0, 0, 0,    100,  0, 24,  0,  0};
        tbl[3]  = '{100, 8, 0, 0, 0,    100,  0, 30,  0,  0};
        tbl[4]  = '{100, 8, 0, 0, 0,    100,  0, 30,  0,  0};
        tbl[5]  = '{100, 0, 1, 0, 250,  100, 100, 30, 0,  0};
        tbl[6]  = '{50,  0, 0, 0, 0,     50, 50, 30,  0,  0};
        tbl[7]  = '{50,  7, 1, 2, 20,    50, 50, 30,  7,  0};
        tbl[8]  = '{50,  7, 1, 2, 5,     50, 50, 30,  5,  0};
        tbl[9]  = '{50,  7, 1, 3, 40,    50, 50, 30,  5,  7};
        tbl[10] = '{20,  7, 0, 0, 0,     20, 43, 23,  5, 14};
        tbl[11] = '{20,  7, 0, 0, 0,     20, 36, 20,  5, 20};

        // Reset, then release with cycle=0: the counter halts with no ticks.
        i_reset = 1'b0; i_cycle = '0; i_step = '0;
        i_cmd_valid = 1'b0; i_cmd_channel = '0; i_cmd_duty = '0;
        repeat (3) @(negedge i_clk);
        check("rst_cmd_ready", {31'd0, o_cmd_ready}, 32'd0);
        check("rst_overrun", {31'd0, o_overrun}, 32'd0);
        i_reset = 1'b1;
        ticks = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge i_clk);
            if (o_period_tick) ticks++;
        end
        check("halt_ticks", ticks, 0);
        check("halt_cmd_ready", {31'd0, o_cmd_ready}, 32'd1);
        check("halt_cycle_out", o_cycle_out, 32'd0);
        check("halt_duty_flat_or", {31'd0, |o_duty_flat}, 32'd0);
        check("halt_flags", {29'd0, o_update_done, o_cmd_err, o_overrun}, 32'd0);

        // cycle=10: cycle_out follows. Check tick spacing, done latency and ready blackout.
        i_cycle = 32'd10;
        repeat (2) @(negedge i_clk);
        check("cycle_out_10", o_cycle_out, 32'd10);
        wait_tick();
        check("tick_clk_ready", {31'd0, o_cmd_ready}, 32'd0);
        ticks = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge i_clk);
            if (k <= 5) check($sformatf("walk_ready_k%0d", k), {31'd0, o_cmd_ready}, 32'd0);
            if (k == 6) check("ready_after_done", {31'd0, o_cmd_ready}, 32'd1);
            check($sformatf("done_at_k%0d", k), {31'd0, o_update_done}, (k == 5) ? 32'd1 : 32'd0);
            if (k < 10 && o_period_tick) ticks++;
        end
        check("tick_spacing_early", ticks, 0);
        check("tick_spacing_10", {31'd0, o_period_tick}, 32'd1);

        // Table-driven slew vectors, one completed walk each.
        for (int v = 0; v < 12; v++) begin
            i_cycle = tbl[v].cyc;
            i_step  = tbl[v].stp;
            if (tbl[v].do_cmd) send_cmd(tbl[v].ch, tbl[v].duty);
            wait_done();
            check($sformatf("v%0d_cycle_out", v), o_cycle_out, tbl[v].exp_cyc);
            check_duties($sformatf("v%0d", v), tbl[v].d0, tbl[v].d1, tbl[v].d2, tbl[v].d3);
        end

        // Bad channel is accepted and flagged, with no state change. Then last-write-wins on ch3.
        i_step = '0;
        send_cmd(3'd5, 32'd3);
        check("cmd_err_pulse", {31'd0, o_cmd_err}, 32'd1);
        @(negedge i_clk);
        check("cmd_err_clear", {31'd0, o_cmd_err}, 32'd0);
        send_cmd(3'd3, 32'd100);
        send_cmd(3'd3, 32'd2);
        wait_done();
        check_duties("err_lww", 32'd20, 32'd20, 32'd5, 32'd2);
        check("overrun_before", {31'd0, o_overrun}, 32'd0);

        // cycle=3: ticks land inside each walk, but each completed walk still steps once.
        i_cycle = 32'd3;
        i_step  = 32'd4;
        wait_done();
        check_duties("ovr_w1", 32'd16, 32'd16, 32'd3, 32'd2);
        wait_done();
        check_duties("ovr_w2", 32'd12, 32'd12, 32'd3, 32'd2);
        check("overrun_set", {31'd0, o_overrun}, 32'd1);
        check("ovr_cycle_out", o_cycle_out, 32'd3);

        // Reset asserted while the walk is at idx=2.
        wait_done();
        wait_tick();
        repeat (3) @(negedge i_clk);
        i_reset = 1'b0;
        #1;
        check("midrst_duty_or", {31'd0, |o_duty_flat}, 32'd0);
        check("midrst_overrun", {31'd0, o_overrun}, 32'd0);
        check("midrst_cmd_ready", {31'd0, o_cmd_ready}, 32'd0);
        check("midrst_cycle_out", o_cycle_out, 32'd0);
        i_cycle = '0;
        @(negedge i_clk);
        i_reset = 1'b1;
        dones = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            if (o_update_done || o_period_tick) dones++;
        end
        check("midrst_idle_quiet", dones, 0);
        check("midrst_idle_ready", {31'd0, o_cmd_ready}, 32'd1);
        // Cleared targets mean a jump walk leaves every duty at 0.
        i_cycle = 32'd10;
        i_step  = '0;
        wait_done();
        check_duties("midrst_targets", 32'd0, 32'd0, 32'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
